fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end of the IF stage.
- Owns the program counter and drives the word address into the instruction memory. The instruction memory returns its word combinationally in the same cycle.
- Captures {instruction, pc} into a 2-entry fetch queue and presents entries to decode with a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute. Flags misaligned or out-of-range fetches as faults.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_DEPTH, 1024, number of 32-bit words in the instruction memory. Word index >= IMEM_DEPTH is out of range.
- NOP_INSTR, 32'h00000013, instruction word emitted with a fault entry.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- redirect_valid  input  1  load redirect_pc this cycle
- redirect_pc  input  32  new fetch byte address
- imem_addr  output  32  word index to instruction memory (pc >> 2, zero-extended)
- imem_data  input  32  instruction word returned combinationally for imem_addr
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  32  head instruction
- out_pc  output  32  byte address of head instruction
- out_fault  output  1  head is a fault entry
- fetch_halted  output  1  fetch stopped after fault, awaiting redirect

Behaviour:
- Reset (rst=1 at posedge):
  - pc <= RESET_PC; queue emptied; halted <= 0.
  - out_valid=0, out_fault=0, out_instr=0, out_pc=0, fetch_halted=0.
  - Reset overrides redirect and all handshakes, including mid-stream with a full queue.
- imem_addr = {2'b00, pc[31:2]}, combinational from the pc register.
- pop = out_valid & out_ready.
- space = (count < 2) | pop.
- Fetch condition = !halted & !redirect_valid & space.
- On a fetch, the pushed entry is one of:
  - Normal (pc[1:0]==0 and pc[31:2] < IMEM_DEPTH): push {imem_data, pc, fault=0}; pc <= pc + 4, wrapping modulo 2^32.
  - Fault (otherwise): push {NOP_INSTR, pc, fault=1}; pc unchanged; halted <= 1. Exactly one fault entry per halt.
- Queue:
  - 2-entry FIFO with head at out_*.
  - Outputs are registered. An instruction fetched in cycle N is visible at out_* in cycle N+1 if the queue was empty.
  - Simultaneous push and pop with count==2 is legal; count stays 2.
  - The head must remain stable while out_valid=1 and out_ready=0.
- Redirect (highest priority below reset):
  - In the cycle redirect_valid=1: no push; next cycle the queue is empty and pc <= redirect_pc; halted <= 0.
  - A pop in the same cycle is honoured by decode but the rest of the queue is discarded.
  - The first fetch from redirect_pc happens the cycle after the redirect, so out_valid rises 2 cycles after redirect_valid.
  - Back-to-back redirects: the last one wins.
- Halted:
  - No fetches; queue drains normally. fetch_halted = halted.
  - Only a redirect or reset clears halted.
- Throughput: 1 instruction/cycle when out_ready is held high.

Test Plan:
- Reset, then out_ready=1 with memory words 0x00000093, 0x00100113, 0x002081b3 -> out_valid rises the cycle after reset release. out_pc sequence 0,4,8 with matching out_instr, one per cycle; imem_addr 0,1,2.
- out_ready=0 for 5 cycles -> queue fills with pc 0 and 4, then fetch stalls with pc=8 held and imem_addr=2. On release, outputs 0,4,8 in order with no duplicates or gaps.
- Queue full, redirect_valid=1 with redirect_pc=0x40 and out_ready=1 in the same cycle -> head pc 0 is consumed, pc 4 is discarded. Next out_pc is 0x40, with out_valid rising 2 cycles after the redirect.
- Redirect to 0x42 -> one entry with out_fault=1, out_pc=0x42, out_instr=0x00000013; fetch_halted=1 and no further entries. A redirect to 0x10 clears the halt and resumes at 0x10.
- Redirect to 0xFFC followed by a sequential fetch (IMEM_DEPTH=1024) -> word 1023 is delivered normally. Next is a fault entry at out_pc=0x1000; halted.
- rst asserted while the queue is full and halted -> next cycle out_valid=0, fetch_halted=0, imem_addr=0. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end: program counter, imem addressing, 2-entry fetch queue, redirects and faults
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic        fetch_halted
);

  logic [31:0] r_pc;
  logic        r_halted;
  logic [1:0]  r_count;
  logic [31:0] r_q_instr [2];
  logic [31:0] r_q_pc    [2];
  logic        r_q_fault [2];

  logic        w_pop;
  logic        w_space;
  logic        w_push;
  logic        w_in_range;
  logic        w_fault;
  logic        w_wr_idx;
  logic [31:0] w_new_instr;

  assign imem_addr    = {2'b00, r_pc[31:2]};
  assign out_valid    = (r_count != 2'd0);
  assign out_instr    = r_q_instr[0];
  assign out_pc       = r_q_pc[0];
  assign out_fault    = r_q_fault[0];
  assign fetch_halted = r_halted;

  assign w_pop       = out_valid & out_ready;
  assign w_space     = (r_count < 2'd2) | w_pop;
  assign w_push      = !r_halted & !redirect_valid & w_space;
  assign w_in_range  = ({2'b00, r_pc[31:2]} < 32'(IMEM_DEPTH));
  assign w_fault     = !((r_pc[1:0] == 2'b00) && w_in_range);
  assign w_new_instr = w_fault ? NOP_INSTR : imem_data;
  // Slot the pushed entry lands in, after any same-cycle pop has shifted the queue.
  assign w_wr_idx    = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc;
      r_halted <= 1'b0;
    end else if (w_push) begin
      if (w_fault) begin
        r_halted <= 1'b1;
      end else begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= 2'd0;
      r_q_instr[0] <= 32'd0;
      r_q_instr[1] <= 32'd0;
      r_q_pc[0]    <= 32'd0;
      r_q_pc[1]    <= 32'd0;
      r_q_fault[0] <= 1'b0;
      r_q_fault[1] <= 1'b0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_q_instr[0] <= r_q_instr[1];
        r_q_pc[0]    <= r_q_pc[1];
        r_q_fault[0] <= r_q_fault[1];
      end
      if (w_push) begin
        r_q_instr[w_wr_idx] <= w_new_instr;
        r_q_pc[w_wr_idx]    <= r_pc;
        r_q_fault[w_wr_idx] <= w_fault;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        fetch_halted;

  logic [31:0] mem [0:1023];
  int checks;
  int errors;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .fetch_halted   (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd1024) ? mem[imem_addr[9:0]] : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h0000_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_81b3;

    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    tick(); tick();
    check("rst_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_fault",  {31'd0, out_fault}, 32'd0);
    check("rst_instr",  out_instr, 32'd0);
    check("rst_pc",     out_pc, 32'd0);
    check("rst_halted", {31'd0, fetch_halted}, 32'd0);
    check("rst_addr",   imem_addr, 32'd0);

    // Streaming at full rate
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("s0_valid", {31'd0, out_valid}, 32'd1);
    check("s0_pc",    out_pc, 32'h0);
    check("s0_instr", out_instr, 32'h0000_0093);
    check("s0_addr",  imem_addr, 32'd1);
    tick();
    check("s1_pc",    out_pc, 32'h4);
    check("s1_instr", out_instr, 32'h0010_0113);
    check("s1_addr",  imem_addr, 32'd2);
    tick();
    check("s2_pc",    out_pc, 32'h8);
    check("s2_instr", out_instr, 32'h0020_81b3);
    check("s2_addr",  imem_addr, 32'd3);

    // Back-pressure: queue fills, head stays put, fetch stalls at pc 8
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_head",  out_pc, 32'h0);
    end
    check("bp_addr", imem_addr, 32'd2);
    out_ready = 1'b1;
    tick();
    check("rel_pc4", out_pc, 32'h4);
    tick();
    check("rel_pc8", out_pc, 32'h8);
    check("rel_instr8", out_instr, 32'h0020_81b3);
    tick();
    check("rel_pc12", out_pc, 32'hC);

    // Redirect with full queue and a same-cycle pop
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    check("rd_full_head", out_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("rd_empty", {31'd0, out_valid}, 32'd0);
    check("rd_addr",  imem_addr, 32'h10);
    tick();
    check("rd_valid", {31'd0, out_valid}, 32'd1);
    check("rd_pc",    out_pc, 32'h40);
    check("rd_instr", out_instr, 32'hA000_0010);

    // Misaligned redirect produces one fault entry then halts
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("mis_valid",  {31'd0, out_valid}, 32'd1);
    check("mis_fault",  {31'd0, out_fault}, 32'd1);
    check("mis_pc",     out_pc, 32'h42);
    check("mis_instr",  out_instr, 32'h0000_0013);
    check("mis_halted", {31'd0, fetch_halted}, 32'd1);
    tick();
    check("mis_drain", {31'd0, out_valid}, 32'd0);
    tick();
    check("mis_still_empty", {31'd0, out_valid}, 32'd0);
    check("mis_still_halt",  {31'd0, fetch_halted}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    check("res_unhalt", {31'd0, fetch_halted}, 32'd0);
    tick();
    check("res_pc",    out_pc, 32'h10);
    check("res_instr", out_instr, 32'hA000_0004);
    check("res_fault", {31'd0, out_fault}, 32'd0);

    // Last in-range word, then out-of-range fault
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("top_pc",    out_pc, 32'hFFC);
    check("top_instr", out_instr, 32'hA000_03FF);
    check("top_fault", {31'd0, out_fault}, 32'd0);
    tick();
    check("oor_pc",     out_pc, 32'h1000);
    check("oor_fault",  {31'd0, out_fault}, 32'd1);
    check("oor_instr",  out_instr, 32'h0000_0013);
    check("oor_halted", {31'd0, fetch_halted}, 32'd1);
    check("oor_addr",   imem_addr, 32'h400);

    // Back-to-back redirects: the second one wins
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("b2b_pc",    out_pc, 32'h20);
    check("b2b_instr", out_instr, 32'hA000_0008);

    // Reset with a full, halted queue
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    check("fh_head",   out_pc, 32'hFFC);
    check("fh_halted", {31'd0, fetch_halted}, 32'd1);
    rst = 1'b1;
    tick();
    check("fh_rst_valid",  {31'd0, out_valid}, 32'd0);
    check("fh_rst_halted", {31'd0, fetch_halted}, 32'd0);
    check("fh_rst_addr",   imem_addr, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("fh_restart_pc",    out_pc, 32'h0);
    check("fh_restart_instr", out_instr, 32'h0000_0093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
